pattern_encoder: RTL and testbench
==================================

// Module: pattern_encoder
// PURPOSE
//  Transmit end of the serial pattern-match link feeding decoder1024. Holds an N-bit code word.
//  PROG phase: shifts the code word out on prgm with enable high for exactly N cycles, loading the decoder.
//  SEND phase: replays the code word on sig, 1..255 back-to-back times, so the decoder's out fires.
//  Lives in the top-level stimulus and self-test path.
// PARAMETERS
//  N    1024            code word width; bits per PROG or SEND frame (N >= 2)
//  CW   $clog2(N)       bit-counter width (derived; do not override)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  clr         in   1   synchronous, active-low reset
//  load        in   1   capture code_in into code register (honoured in IDLE only)
//  code_in     in   N   code word; bit N-1 is transmitted first
//  prog_start  in   1   request PROG phase (honoured in IDLE only)
//  send_start  in   1   request SEND phase (honoured in IDLE with programmed=1 only)
//  reps        in   8   SEND repetitions, sampled with send_start; 0 is treated as 1
//  abort       in   1   terminate PROG/SEND, return to IDLE
//  prgm        out  1   serial program bit to decoder
//  enable      out  1   program-load enable to decoder; high only during PROG bits
//  sig         out  1   serial signal bit to decoder
//  busy        out  1   high in PROG or SEND
//  done        out  1   one-cycle pulse after last bit of a completed phase
//  programmed  out  1   PROG has completed since reset or last load
//  err         out  1   one-cycle pulse: send_start rejected (programmed=0)
// BEHAVIOUR
//  - Reset (clr=0 at posedge): state=IDLE, code=0, counters=0, all outputs 0. Reset overrides every input.
//  - All outputs are registered. No combinational input-to-output path.
//  - FSM states:
//    - IDLE -> PROG on prog_start.
//    - IDLE -> SEND on send_start && programmed && !prog_start.
//    - PROG/SEND -> IDLE on completion or abort.
//  - Priority in IDLE: load, then prog_start, then send_start.
//    - load and a start in the same cycle: load is applied; the start then uses the NEW code word.
//  - load in IDLE: code <= code_in; programmed <= 0. load outside IDLE is ignored.
//  - PROG timing (start sampled at edge k):
//    - From edge k: enable=1, prgm=code[N-1].
//    - Edge k+i: prgm=code[N-1-i] for i=0..N-1.
//    - Edge k+N: enable=0, prgm=0, done=1, programmed=1, state=IDLE.
//    - Exactly N enable-high cycles.
//  - SEND timing:
//    - Same cadence as PROG, on sig; enable stays 0.
//    - R = max(reps,1) frames are sent back-to-back with no gap; bit counter wraps N-1 -> 0.
//    - done pulses at edge k+R*N.
//  - sig=0 and prgm=0 whenever not driving a bit. busy = (state != IDLE).
//  - abort in PROG/SEND: next edge goes to IDLE; prgm/sig/enable=0; no done.
//    - An aborted PROG leaves programmed=0. abort in IDLE has no effect.
//  - Starts while busy are ignored (not queued). done and err are never high together.
//  - send_start with programmed=0: stay IDLE; err=1 for one cycle.
//  - done clears the next cycle, even if a new start is sampled in that cycle.
//    - A start in the done cycle begins the next phase at the following edge.
// TESTING (bench with N=8 plus one N=1024 smoke run)
//  1. Reset mid-SEND: clr=0 one cycle -> all outputs 0 next cycle; programmed=0.
//  2. load 8'hA5, prog_start -> enable high exactly 8 cycles.
//     - prgm sequence 1,0,1,0,0,1,0,1.
//     - done 1 cycle after the last bit; programmed=1.
//  3. send_start, reps=3 -> sig = A5 A5 A5, 24 contiguous bits.
//     - busy high 24 cycles; done 1 cycle after the last bit; enable stays 0.
//  4. After load 8'h3C (programmed=0), send_start -> err one cycle, busy stays 0.
//     - prog_start and send_start in the same cycle -> PROG runs.
//  5. abort at bit 4 of PROG -> outputs 0 next cycle; no done; programmed=0.
//     - prog_start, load and send_start while busy are all ignored.
//  6. N=1024 with decoder1024: load 128 ones + 896 zeros, then PROG, then SEND reps=2.
//     - Decoder out asserts once per completed frame.

Source files
------------

// File: rtl/pattern_encoder.sv
// Serial pattern-match link transmitter: holds an N-bit code word, shifts it out MSB-first
// on prgm/enable to program the decoder, then replays it on sig for a chosen number of frames.
module pattern_encoder #(
    parameter int N = 1024
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] code_in,
    input  logic         prog_start,
    input  logic         send_start,
    input  logic [7:0]   reps,
    input  logic         abort,
    output logic         prgm,
    output logic         enable,
    output logic         sig,
    output logic         busy,
    output logic         done,
    output logic         programmed,
    output logic         err
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  code_reg, code_next, code_eff;
    logic [CW-1:0] bit_reg, bit_next, bit_inc, bit_sel;
    logic [7:0]    rep_reg, rep_next;
    logic          prgm_reg, prgm_next;
    logic          enable_reg, enable_next;
    logic          sig_reg, sig_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          programmed_reg, programmed_next, programmed_eff;

    // bit_reg is the index of the bit currently on the wire; bit_sel picks the next one
    assign bit_inc = bit_reg + CW'(1);
    assign bit_sel = LAST - bit_inc;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg      <= IDLE;
            code_reg       <= '0;
            bit_reg        <= '0;
            rep_reg        <= '0;
            prgm_reg       <= 1'b0;
            enable_reg     <= 1'b0;
            sig_reg        <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            programmed_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            code_reg       <= code_next;
            bit_reg        <= bit_next;
            rep_reg        <= rep_next;
            prgm_reg       <= prgm_next;
            enable_reg     <= enable_next;
            sig_reg        <= sig_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            programmed_reg <= programmed_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        code_next       = code_reg;
        bit_next        = bit_reg;
        rep_next        = rep_reg;
        prgm_next       = 1'b0;
        enable_next     = 1'b0;
        sig_next        = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        programmed_next = programmed_reg;
        code_eff        = code_reg;
        programmed_eff  = programmed_reg;

        case (state_reg)
            IDLE: begin
                // A same-cycle load is visible to a start sampled in that cycle
                if (load) begin
                    code_next       = code_in;
                    code_eff        = code_in;
                    programmed_next = 1'b0;
                    programmed_eff  = 1'b0;
                end
                if (prog_start) begin
                    state_next      = PROG;
                    bit_next        = '0;
                    prgm_next       = code_eff[N-1];
                    enable_next     = 1'b1;
                    programmed_next = 1'b0;
                end else if (send_start) begin
                    if (programmed_eff) begin
                        state_next = SEND;
                        bit_next   = '0;
                        rep_next   = (reps == 8'd0) ? 8'd1 : reps;
                        sig_next   = code_eff[N-1];
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            PROG: begin
                if (abort) begin
                    state_next = IDLE;
                    bit_next   = '0;
                end else if (bit_reg == LAST) begin
                    state_next      = IDLE;
                    bit_next        = '0;
                    done_next       = 1'b1;
                    programmed_next = 1'b1;
                end else begin
                    bit_next    = bit_inc;
                    prgm_next   = code_reg[bit_sel];
                    enable_next = 1'b1;
                end
            end

            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                    bit_next   = '0;
                    rep_next   = '0;
                end else if (bit_reg == LAST) begin
                    if (rep_reg <= 8'd1) begin
                        state_next = IDLE;
                        bit_next   = '0;
                        rep_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        // Frames run back-to-back: wrap straight to the MSB
                        rep_next = rep_reg - 8'd1;
                        bit_next = '0;
                        sig_next = code_reg[N-1];
                    end
                end else begin
                    bit_next = bit_inc;
                    sig_next = code_reg[bit_sel];
                end
            end

            default: begin
                state_next = IDLE;
                bit_next   = '0;
                rep_next   = '0;
            end
        endcase
    end

    assign prgm       = prgm_reg;
    assign enable     = enable_reg;
    assign sig        = sig_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign programmed = programmed_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_pattern_encoder.sv
// Directed bench for pattern_encoder: an N=8 instance for protocol checks and an N=1024
// instance for a long-frame smoke run.
module tb_pattern_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        load, prog_start, send_start, abort;
    logic [7:0]  code_in, reps;
    logic        prgm, enable, sig, busy, done, programmed, err;

    logic          load_b, prog_b, send_b, abort_b;
    logic [1023:0] code_b;
    logic [7:0]    reps_b;
    logic          prgm_b, enable_b, sig_b, busy_b, done_b, programmed_b, err_b;

    int tests = 0;
    int fails = 0;

    pattern_encoder #(.N(8)) dut (
        .clk(clk), .clr(clr), .load(load), .code_in(code_in),
        .prog_start(prog_start), .send_start(send_start), .reps(reps), .abort(abort),
        .prgm(prgm), .enable(enable), .sig(sig), .busy(busy), .done(done),
        .programmed(programmed), .err(err)
    );

    pattern_encoder #(.N(1024)) dut_big (
        .clk(clk), .clr(clr), .load(load_b), .code_in(code_b),
        .prog_start(prog_b), .send_start(send_b), .reps(reps_b), .abort(abort_b),
        .prgm(prgm_b), .enable(enable_b), .sig(sig_b), .busy(busy_b), .done(done_b),
        .programmed(programmed_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {prgm, enable, sig, busy, done, programmed, err};
    endfunction

    // Entered with bit 0 of the frame on the wire; leaves after the edge following bit 7
    task automatic check_frame(input string tag, input logic [7:0] w, input logic is_prog);
        for (int i = 0; i < 8; i++) begin
            if (is_prog) begin
                check($sformatf("%s_prgm%0d", tag, i), prgm, w[7-i]);
                check($sformatf("%s_en%0d", tag, i), enable, 1'b1);
            end else begin
                check($sformatf("%s_sig%0d", tag, i), sig, w[7-i]);
                check($sformatf("%s_en%0d", tag, i), enable, 1'b0);
            end
            check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            tick();
        end
    endtask

    initial begin
        int bad;
        int en_cnt;
        logic exp_bit;

        clr = 1'b0; load = 1'b0; prog_start = 1'b0; send_start = 1'b0; abort = 1'b0;
        code_in = 8'h00; reps = 8'd0;
        load_b = 1'b0; prog_b = 1'b0; send_b = 1'b0; abort_b = 1'b0;
        code_b = '0; reps_b = 8'd0;
        tick();
        tick();
        check("reset_outs", outs(), 7'b0);
        clr = 1'b1;
        $display("[TB] reset checked");

        // Program A5
        code_in = 8'hA5; load = 1'b1; tick(); load = 1'b0;
        check("load_programmed", programmed, 1'b0);
        check("load_busy", busy, 1'b0);
        prog_start = 1'b1; tick(); prog_start = 1'b0;
        check_frame("progA5", 8'hA5, 1'b1);
        check("progA5_done", done, 1'b1);
        check("progA5_programmed", programmed, 1'b1);
        check("progA5_en_off", enable, 1'b0);
        check("progA5_busy_off", busy, 1'b0);
        check("progA5_prgm_off", prgm, 1'b0);
        tick();
        check("progA5_done_clear", done, 1'b0);
        $display("[TB] PROG A5 complete");

        // Send A5 three times; reps changed after sampling must not matter
        reps = 8'd3; send_start = 1'b1; tick(); send_start = 1'b0; reps = 8'd0;
        repeat (3) check_frame("sendA5", 8'hA5, 1'b0);
        check("sendA5_done", done, 1'b1);
        check("sendA5_busy_off", busy, 1'b0);
        check("sendA5_sig_off", sig, 1'b0);
        tick();
        check("sendA5_done_clear", done, 1'b0);
        $display("[TB] SEND A5 x3 complete");

        // New code invalidates programming; send is rejected
        code_in = 8'h3C; load = 1'b1; tick(); load = 1'b0;
        check("load3C_programmed", programmed, 1'b0);
        send_start = 1'b1; tick(); send_start = 1'b0;
        check("reject_err", err, 1'b1);
        check("reject_busy", busy, 1'b0);
        check("reject_done", done, 1'b0);
        tick();
        check("reject_err_clear", err, 1'b0);
        $display("[TB] unprogrammed send rejected");

        // prog_start wins over send_start
        prog_start = 1'b1; send_start = 1'b1; tick(); prog_start = 1'b0; send_start = 1'b0;
        check_frame("prog3C", 8'h3C, 1'b1);
        check("prog3C_done", done, 1'b1);
        check("prog3C_programmed", programmed, 1'b1);
        check("prog3C_err", err, 1'b0);
        tick();
        $display("[TB] PROG 3C complete");

        // load + prog_start together uses the new word; busy-time requests are ignored; abort at bit 4
        code_in = 8'h96; load = 1'b1; prog_start = 1'b1; tick();
        load = 1'b0; prog_start = 1'b0; code_in = 8'h00;
        check("prog96_b0", prgm, 1'b1); tick();
        check("prog96_b1", prgm, 1'b0); tick();
        check("prog96_b2", prgm, 1'b0);
        prog_start = 1'b1; load = 1'b1; send_start = 1'b1; tick();
        prog_start = 1'b0; load = 1'b0; send_start = 1'b0;
        check("prog96_b3", prgm, 1'b1);
        check("prog96_busy3", busy, 1'b1); tick();
        check("prog96_b4", prgm, 1'b0);
        check("prog96_en4", enable, 1'b1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_outs", outs(), 7'b0);
        tick();
        check("abort_no_done", outs(), 7'b0);
        $display("[TB] PROG aborted at bit 4");

        // Code word must still be 96 despite the busy-time load
        prog_start = 1'b1; tick(); prog_start = 1'b0;
        check_frame("prog96", 8'h96, 1'b1);
        check("prog96_done", done, 1'b1);
        check("prog96_programmed", programmed, 1'b1);
        tick();

        // reps=0 behaves as one frame
        reps = 8'd0; send_start = 1'b1; tick(); send_start = 1'b0;
        check_frame("send96r0", 8'h96, 1'b0);
        check("send96r0_done", done, 1'b1);
        check("send96r0_busy", busy, 1'b0);
        tick();
        $display("[TB] SEND reps=0 single frame");

        // Reset mid-SEND
        reps = 8'd2; send_start = 1'b1; tick(); send_start = 1'b0;
        repeat (5) tick();
        check("midsend_busy", busy, 1'b1);
        clr = 1'b0; tick(); clr = 1'b1;
        check("midsend_reset_outs", outs(), 7'b0);
        tick();
        check("after_reset_idle", outs(), 7'b0);
        $display("[TB] reset mid-SEND");

        // N=1024 smoke: 128 ones then 896 zeros
        code_b = {{128{1'b1}}, {896{1'b0}}};
        load_b = 1'b1; tick(); load_b = 1'b0;
        prog_b = 1'b1; tick(); prog_b = 1'b0;
        bad = 0;
        en_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            exp_bit = (i < 128);
            if (prgm_b !== exp_bit) bad++;
            if (enable_b === 1'b1) en_cnt++;
            tick();
        end
        check("big_prog_bits", bad, 0);
        check("big_en_cnt", en_cnt, 1024);
        check("big_prog_done", done_b, 1'b1);
        check("big_programmed", programmed_b, 1'b1);
        tick();
        reps_b = 8'd2; send_b = 1'b1; tick(); send_b = 1'b0;
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            exp_bit = ((i % 1024) < 128);
            if (sig_b !== exp_bit) bad++;
            if (busy_b !== 1'b1) bad++;
            tick();
        end
        check("big_send_bits", bad, 0);
        check("big_send_done", done_b, 1'b1);
        check("big_send_busy_off", busy_b, 1'b0);
        $display("[TB] N=1024 PROG + SEND x2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
